// File: rtl/tone_gen.sv
// rtl/tone_gen.sv - square-wave tone generator with boundary-aligned note changes
// and a drain state that never truncates a high half-period.
module tone_gen #(
  parameter int CNT_WIDTH    = 26,
  parameter int DEFAULT_HALF = 95500,
  parameter int OCT_WIDTH    = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 note_load,
  input  logic [CNT_WIDTH-1:0] note_half,
  input  logic [OCT_WIDTH-1:0] octave,
  output logic                 freqOut,
  output logic                 edge_pulse,
  output logic                 active
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 freq_q, freq_d;
  logic                 edge_q, edge_d;
  logic                 active_q, active_d;
  logic [CNT_WIDTH-1:0] active_half_q, active_half_d;
  logic [OCT_WIDTH-1:0] active_oct_q, active_oct_d;
  logic [CNT_WIDTH-1:0] pend_half_q, pend_half_d;
  logic [OCT_WIDTH-1:0] pend_oct_q, pend_oct_d;
  logic                 pend_valid_q, pend_valid_d;

  logic [CNT_WIDTH-1:0] shifted;
  logic [CNT_WIDTH-1:0] term;
  logic                 run_ok;
  logic                 at_term;
  logic                 boundary;

  always_comb begin
    shifted  = active_half_q >> active_oct_q;
    term     = (shifted == '0 && active_half_q != '0) ? CNT_WIDTH'(1) : shifted;
    run_ok   = enable && (active_half_q != '0);
    at_term  = (cnt_q == term);
    boundary = 1'b0;

    state_d       = state_q;
    cnt_d         = cnt_q;
    freq_d        = freq_q;
    edge_d        = 1'b0;
    active_half_d = active_half_q;
    active_oct_d  = active_oct_q;
    pend_half_d   = pend_half_q;
    pend_oct_d    = pend_oct_q;
    pend_valid_d  = pend_valid_q;

    unique case (state_q)
      IDLE: begin
        cnt_d  = '0;
        freq_d = 1'b0;
        // A pending note stranded by a stop from the low phase is promoted here.
        if (note_load) begin
          active_half_d = note_half;
          active_oct_d  = octave;
          pend_valid_d  = 1'b0;
        end else if (pend_valid_q) begin
          active_half_d = pend_half_q;
          active_oct_d  = pend_oct_q;
          pend_valid_d  = 1'b0;
        end
        if (run_ok) state_d = RUN;
      end
      RUN, DRAIN: begin
        if (state_q == RUN && !run_ok && !freq_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          if (at_term) begin
            boundary = 1'b1;
            cnt_d    = '0;
            freq_d   = !freq_q;
            edge_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
          end
          // Stopping is only ever reached from the high phase here, so the
          // terminal boundary is the falling edge.
          if (run_ok)       state_d = RUN;
          else if (at_term) state_d = IDLE;
          else              state_d = DRAIN;
        end

        if (boundary) begin
          if (note_load) begin
            active_half_d = note_half;
            active_oct_d  = octave;
            pend_valid_d  = 1'b0;
          end else if (pend_valid_q) begin
            active_half_d = pend_half_q;
            active_oct_d  = pend_oct_q;
            pend_valid_d  = 1'b0;
          end
        end else if (note_load) begin
          pend_half_d  = note_half;
          pend_oct_d   = octave;
          pend_valid_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        freq_d  = 1'b0;
      end
    endcase

    active_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      freq_q        <= 1'b0;
      edge_q        <= 1'b0;
      active_q      <= 1'b0;
      active_half_q <= CNT_WIDTH'(DEFAULT_HALF);
      active_oct_q  <= '0;
      pend_half_q   <= '0;
      pend_oct_q    <= '0;
      pend_valid_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      freq_q        <= freq_d;
      edge_q        <= edge_d;
      active_q      <= active_d;
      active_half_q <= active_half_d;
      active_oct_q  <= active_oct_d;
      pend_half_q   <= pend_half_d;
      pend_oct_q    <= pend_oct_d;
      pend_valid_q  <= pend_valid_d;
    end
  end

  assign freqOut    = freq_q;
  assign edge_pulse = edge_q;
  assign active     = active_q;

endmodule

// File: tb/tb_tone_gen.sv
// tb/tb_tone_gen.sv - scoreboard bench for tone_gen: expected toggle level and
// half-period length are queued by stimulus and checked on every edge_pulse.
module tb_tone_gen;

  localparam int CW = 26;
  localparam int OW = 3;

  typedef struct packed {
    logic        lvl;
    logic [31:0] len;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          note_load;
  logic [CW-1:0] note_half;
  logic [OW-1:0] octave;
  logic          freqOut;
  logic          edge_pulse;
  logic          active;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_evt = 0;
  logic prev_freq = 1'b0;
  exp_t exp_q[$];

  tone_gen #(.CNT_WIDTH(CW), .DEFAULT_HALF(4), .OCT_WIDTH(OW)) dut (
    .clk(clk), .reset(reset), .enable(enable), .note_load(note_load),
    .note_half(note_half), .octave(octave), .freqOut(freqOut),
    .edge_pulse(edge_pulse), .active(active)
  );

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (reset) begin
      prev_freq = freqOut;
    end else begin
      if (edge_pulse) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_edge cycle=%0d freqOut=%0d", cyc, freqOut);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (freqOut !== e.lvl || (cyc - last_evt) != int'(e.len)) begin
            errors++;
            $display("FAIL edge cycle=%0d got lvl=%0d len=%0d exp lvl=%0d len=%0d",
                     cyc, freqOut, cyc - last_evt, e.lvl, e.len);
          end
        end
        last_evt = cyc;
      end else if (freqOut !== prev_freq) begin
        checks++;
        errors++;
        $display("FAIL toggle_without_edge cycle=%0d got=%0d exp=%0d", cyc, freqOut, prev_freq);
      end
      prev_freq = freqOut;
    end
  end

  task automatic nstep();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic lvl, input int len);
    exp_t e;
    e.lvl = lvl;
    e.len = 32'(len);
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic wait_empty(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      nstep();
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout_%s got=%0d pending exp=0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic load(input int half, input int oct);
    note_load = 1'b1;
    note_half = CW'(half);
    octave    = OW'(oct);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; note_load = 1'b0; note_half = '0; octave = '0;
    nstep(); nstep();
    chk("reset_freq", freqOut, 1'b0);
    chk("reset_edge", edge_pulse, 1'b0);
    chk("reset_active", active, 1'b0);
    reset = 1'b0;

    // Default term 4: five-cycle halves from RUN entry.
    nstep();
    enable = 1'b1; last_evt = cyc + 1;
    push(1, 5); push(0, 5); push(1, 5); push(0, 5);
    wait_empty("default");
    enable = 1'b0;
    nstep();
    chk("stop_low_idle", active, 1'b0);

    // Load half=2 at counter=1: current half finishes at 5, then 3-cycle halves.
    enable = 1'b1; last_evt = cyc + 1;
    push(1, 5); push(0, 3); push(1, 3); push(0, 3);
    nstep(); nstep();
    load(2, 0);
    nstep();
    note_load = 1'b0;
    wait_empty("pending");
    enable = 1'b0;
    nstep();
    chk("pending_idle", active, 1'b0);

    // Octave shift and clamp.
    load(9, 1);
    nstep();
    note_load = 1'b0; enable = 1'b1; last_evt = cyc + 1;
    push(1, 5); push(0, 5);
    wait_empty("oct1");
    enable = 1'b0;
    nstep();
    chk("oct1_idle", active, 1'b0);
    load(9, 7);
    nstep();
    note_load = 1'b0; enable = 1'b1; last_evt = cyc + 1;
    push(1, 2); push(0, 2); push(1, 2); push(0, 2);
    wait_empty("clamp");
    enable = 1'b0;
    nstep();
    chk("clamp_idle", active, 1'b0);

    // Drain from high phase at counter=2.
    load(9, 1);
    nstep();
    note_load = 1'b0; enable = 1'b1; last_evt = cyc + 1;
    push(1, 5);
    wait_empty("drain_rise");
    nstep(); nstep();
    enable = 1'b0;
    push(0, 5);
    wait_empty("drain_fall");
    chk("drain_idle", active, 1'b0);

    // Re-raise enable during DRAIN: no phase slip.
    enable = 1'b1; last_evt = cyc + 1;
    push(1, 5);
    wait_empty("rearm_rise");
    nstep();
    enable = 1'b0;
    nstep();
    chk("drain_active", active, 1'b1);
    enable = 1'b1;
    push(0, 5); push(1, 5);
    wait_empty("rearm");

    // Reset mid-RUN with freqOut=1, after a pending load that reset must discard.
    load(2, 0);
    nstep();
    note_load = 1'b0; reset = 1'b1;
    nstep();
    chk("midrun_freq", freqOut, 1'b0);
    chk("midrun_active", active, 1'b0);
    chk("midrun_edge", edge_pulse, 1'b0);
    reset = 1'b0; last_evt = cyc + 1;
    push(1, 5); push(0, 5); push(1, 5);
    wait_empty("after_reset");

    // Mute via pending load of 0.
    load(0, 0);
    push(0, 5);
    nstep();
    note_load = 1'b0;
    wait_empty("mute");
    nstep();
    chk("mute_idle", active, 1'b0);
    nstep();
    chk("mute_stays_idle", active, 1'b0);

    // Load coinciding with a boundary applies at that boundary.
    load(4, 0);
    last_evt = cyc + 2;
    push(1, 5);
    nstep();
    note_load = 1'b0;
    wait_empty("sim_rise");
    nstep(); nstep(); nstep(); nstep();
    load(1, 0);
    push(0, 5); push(1, 2); push(0, 2);
    nstep();
    note_load = 1'b0;
    wait_empty("sim_load");
    enable = 1'b0;
    nstep();
    chk("final_idle", active, 1'b0);
    repeat (10) nstep();
    chk("final_freq", freqOut, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
